// File: rtl/fifo_wr_arb_if.sv
`timescale 1ns/1ps
// Bundles the requester handshake and the write-controller / RAM write-port signals of fifo_wr_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface fifo_wr_arb_if #(
    parameter int P_NUM_REQ = 4,
    parameter int P_DATA_W  = 32,
    parameter int P_PTR_MSB = 4,
    parameter int P_SEL_W   = 2
);
    logic [P_NUM_REQ-1:0]          i_req_valid;
    logic [P_NUM_REQ*P_DATA_W-1:0] i_req_data;
    logic [P_NUM_REQ-1:0]          i_req_last;
    logic [P_NUM_REQ-1:0]          o_req_ready;
    logic [P_PTR_MSB:0]            i_wr_ptr;
    logic [P_PTR_MSB:0]            i_rd_ptr;
    logic                          o_wr_inc;
    logic [P_DATA_W-1:0]           o_wr_data;
    logic [P_SEL_W-1:0]            o_wr_src;
    logic                          o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_wr_ptr, i_rd_ptr,
        output o_req_ready, o_wr_inc, o_wr_data, o_wr_src, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_wr_ptr, i_rd_ptr,
        input  o_req_ready, o_wr_inc, o_wr_data, o_wr_src, o_busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing the dual-clock FIFO write port among P_NUM_REQ requesters, throttled on free space.
// Define FIFO_WR_ARB_PKT_LOCK_EN to hold the port for a whole packet (first beat through i_req_last).
//
// state   | meaning
// ST_IDLE | beat-level round-robin among all valid requesters
// ST_LOCK | packet in progress; only owner_q is eligible
module fifo_wr_arb #(
    parameter int P_NUM_REQ = 4,
    parameter int P_DATA_W  = 32,
    parameter int P_PTR_MSB = 4,
    parameter int P_SEL_W   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fifo_wr_arb_if.slave  bus
);
    localparam int          PW  = P_PTR_MSB + 1;
    localparam logic [PW:0] CAP = {1'b0, {PW{1'b1}}};

    logic [P_SEL_W-1:0]   last_q, last_d;
    logic                 wr_inc_q, wr_inc_d;
    logic [P_DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [P_SEL_W-1:0]   wr_src_q, wr_src_d;

    logic [P_DATA_W-1:0]  req_data [P_NUM_REQ];
    logic [PW-1:0]        used;
    logic [PW:0]          used_tot;
    logic                 space_ok;
    logic [P_NUM_REQ-1:0] owner_mask, elig, rot, rdy;
    logic                 any_elig, accept, lock_act;
    logic [P_SEL_W-1:0]   offs, win_idx;
    logic [P_DATA_W-1:0]  win_data;

    for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_slice
        assign req_data[g] = bus.i_req_data[g*P_DATA_W +: P_DATA_W];
    end

    // o_wr_inc stands in for the issued write not yet visible in i_wr_ptr
    always_comb begin
        used     = bus.i_wr_ptr - bus.i_rd_ptr;
        used_tot = {1'b0, used} + {{PW{1'b0}}, wr_inc_q};
        space_ok = used_tot < CAP;
    end

    always_comb begin
        elig     = bus.i_req_valid & owner_mask;
        any_elig = |elig;
        rot      = P_NUM_REQ'({elig, elig} >> (int'(last_q) + 1));
        offs     = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) offs = P_SEL_W'(i);
        end
        win_idx  = P_SEL_W'((int'(last_q) + 1 + int'(offs)) % P_NUM_REQ);
        accept   = any_elig & space_ok;
        rdy      = '0;
        win_data = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (win_idx == P_SEL_W'(k)) begin
                rdy[k]   = accept;
                win_data = req_data[k];
            end
        end
    end

    always_comb begin
        last_d    = last_q;
        wr_inc_d  = accept;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (accept) begin
            last_d    = win_idx;
            wr_data_d = win_data;
            wr_src_d  = win_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q    <= P_SEL_W'(P_NUM_REQ - 1);
            wr_inc_q  <= 1'b0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
        end else begin
            last_q    <= last_d;
            wr_inc_q  <= wr_inc_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    typedef enum logic [0:0] {ST_IDLE, ST_LOCK} state_t;

    state_t             state_q, state_d;
    logic [P_SEL_W-1:0] owner_q, owner_d;
    logic               win_last;

    assign lock_act = (state_q == ST_LOCK);

    // kept apart from the FSM block so the mask never sits in a loop with win_idx
    always_comb begin
        owner_mask = '1;
        if (lock_act) begin
            for (int k = 0; k < P_NUM_REQ; k++) owner_mask[k] = (owner_q == P_SEL_W'(k));
        end
    end

    always_comb begin
        win_last = 1'b0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (win_idx == P_SEL_W'(k)) win_last = bus.i_req_last[k];
        end
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !win_last) begin
                    state_d = ST_LOCK;
                    owner_d = win_idx;
                end
            end
            ST_LOCK: begin
                if (accept && win_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    assign lock_act   = 1'b0;
    assign owner_mask = '1;
`endif

    assign bus.o_req_ready = rdy;
    assign bus.o_wr_inc    = wr_inc_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_wr_src    = wr_src_q;
    assign bus.o_busy      = lock_act | wr_inc_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
`timescale 1ns/1ps
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic against a behavioural model.
// The write controller is emulated by a pointer that advances one cycle after each o_wr_inc.
module tb_fifo_wr_arb;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int PM   = 4;
    localparam int SW   = 2;
    localparam int PW   = PM + 1;
    localparam int MODV = 1 << PW;
    localparam int CAPM = MODV - 1;
    localparam int BW   = N + 1 + SW + DW + 1;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arb_if #(.P_NUM_REQ(N), .P_DATA_W(DW), .P_PTR_MSB(PM), .P_SEL_W(SW)) bus();
    fifo_wr_arb #(.P_NUM_REQ(N), .P_DATA_W(DW), .P_PTR_MSB(PM), .P_SEL_W(SW)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [PW-1:0] wr_ptr_q = '0;
    logic [PW-1:0] rd_ptr   = '0;
    logic [PW-1:0] load_val = '0;
    bit            load_en  = 1'b0;
    bit            vld [N];
    bit            lst [N];
    logic [DW-1:0] dat [N];

    always @(posedge clk) begin
        if (rst)                wr_ptr_q <= '0;
        else if (load_en)       wr_ptr_q <= load_val;
        else if (bus.o_wr_inc)  wr_ptr_q <= wr_ptr_q + 1'b1;
    end

    assign bus.i_wr_ptr = wr_ptr_q;
    assign bus.i_rd_ptr = rd_ptr;

    always_comb begin
        bus.i_req_valid = '0;
        bus.i_req_last  = '0;
        bus.i_req_data  = '0;
        for (int k = 0; k < N; k++) begin
            bus.i_req_valid[k]          = vld[k];
            bus.i_req_last[k]           = lst[k];
            bus.i_req_data[k*DW +: DW]  = dat[k];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    int            m_last;
    bit            m_locked;
    int            m_owner;
    bit            m_inc;
    logic [DW-1:0] m_data;
    int            m_src;

    task automatic model_reset();
        m_last = N - 1; m_locked = 0; m_owner = 0; m_inc = 0; m_data = '0; m_src = 0;
    endtask

    task automatic model_eval(output logic [N-1:0] r, output int win, output bit acc);
        int used;
        used = (int'(wr_ptr_q) - int'(rd_ptr) + MODV) % MODV;
        win = -1;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_last + i) % N;
            if (win < 0 && vld[k] && (!m_locked || k == m_owner)) win = k;
        end
        acc = (win >= 0) && ((used + int'(m_inc)) < CAPM);
        r = '0;
        if (acc) r = N'(1) << win;
    endtask

    task automatic model_commit(input int win, input bit acc);
        if (acc) begin
            m_last = win; m_inc = 1; m_data = dat[win]; m_src = win;
            if (LOCK_EN) begin
                if (!m_locked && !lst[win]) begin m_locked = 1; m_owner = win; end
                else if (m_locked && lst[win]) m_locked = 0;
            end
        end else begin
            m_inc = 0;
        end
    endtask

    task automatic step(output logic [BW-1:0] obs, output logic [BW-1:0] exp,
                        output int win, output bit acc);
        logic [N-1:0] r_obs, r_exp;
        #1;
        r_obs = bus.o_req_ready;
        model_eval(r_exp, win, acc);
        model_commit(win, acc);
        @(posedge clk); #1;
        obs = {r_obs, bus.o_wr_inc, bus.o_wr_src, bus.o_wr_data, bus.o_busy};
        exp = {r_exp, m_inc, SW'(m_src), m_data, m_locked | m_inc};
    endtask

    task automatic apply_reset();
        rst = 1'b1; load_en = 1'b0; rd_ptr = '0;
        for (int k = 0; k < N; k++) begin vld[k] = 0; lst[k] = 1; dat[k] = $urandom; end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin vld[k] = 1; lst[k] = $urandom_range(0, 1) == 1; dat[k] = $urandom; end
        rd_ptr = PW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        if ({bus.o_wr_inc, bus.o_wr_src, bus.o_wr_data, bus.o_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs got inc=%b src=%0d data=%h busy=%b exp all 0",
                     bus.o_wr_inc, bus.o_wr_src, bus.o_wr_data, bus.o_busy);
        end
        vectors++;
        rd_ptr = '0;
        rst = 1'b0;
        model_reset();
        #1;
        if (bus.o_req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_winner got ready=%b exp 0001", bus.o_req_ready);
        end
        vectors++;
        for (int k = 0; k < N; k++) vld[k] = 0;
    endtask

    task automatic test_alternate();
        logic [BW-1:0] obs, exp;
        int win; bit acc;
        int seq[$];
        apply_reset();
        vld[0] = 1; vld[2] = 1;
        for (int c = 0; c < 8; c++) begin
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL alt_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (bus.o_wr_inc) seq.push_back(int'(bus.o_wr_src));
            if (acc) dat[win] = $urandom;
        end
        if (seq.size() != 8) begin
            miscompares++;
            $display("FAIL alt_count got=%0d exp=8", seq.size());
        end
        vectors++;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] != (i % 2) * 2) begin
                miscompares++;
                $display("FAIL alt_order i=%0d got src=%0d exp=%0d", i, seq[i], (i % 2) * 2);
            end
            vectors++;
        end
    endtask

    task automatic test_full();
        logic [BW-1:0] obs, exp;
        int win; bit acc; int writes;
        apply_reset();
        vld[1] = 1;
        writes = 0;
        for (int c = 0; c < 45; c++) begin
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL full_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (bus.o_wr_inc) writes++;
            if (acc) dat[1] = $urandom;
        end
        if (writes != CAPM) begin
            miscompares++;
            $display("FAIL full_writes got=%0d exp=%0d", writes, CAPM);
        end
        vectors++;
        if (bus.o_req_ready !== '0) begin
            miscompares++;
            $display("FAIL full_ready got=%b exp 0000", bus.o_req_ready);
        end
        vectors++;
        rd_ptr = rd_ptr + 1'b1;
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL full_drain_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (bus.o_wr_inc) writes++;
            if (acc) dat[1] = $urandom;
        end
        if (writes != 1) begin
            miscompares++;
            $display("FAIL full_one_more got=%0d exp=1", writes);
        end
        vectors++;
    endtask

    task automatic test_wrap();
        logic [BW-1:0] obs, exp;
        int win; bit acc; int writes;
        apply_reset();
        load_val = PW'(30); load_en = 1'b1; rd_ptr = PW'(31);
        @(posedge clk); #1;
        load_en = 1'b0;
        vld[0] = 1;
        #1;
        if (bus.o_req_ready !== '0) begin
            miscompares++;
            $display("FAIL wrap_full_ready got=%b exp 0000", bus.o_req_ready);
        end
        vectors++;
        rd_ptr = '0;
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL wrap_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (bus.o_wr_inc) writes++;
            if (acc) dat[0] = $urandom;
        end
        if (writes != 1) begin
            miscompares++;
            $display("FAIL wrap_writes got=%0d exp=1", writes);
        end
        vectors++;
    endtask

    task automatic test_packet();
        logic [BW-1:0] obs, exp;
        int win; bit acc; int beats;
        int seq[$];
        int exp_lk[6] = '{3, 3, 3, 3, 0, 0};
        int exp_rr[6] = '{3, 0, 3, 0, 3, 0};
        apply_reset();
        vld[3] = 1; lst[3] = 0; beats = 0;
        for (int c = 0; c < 12; c++) begin
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pkt_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (bus.o_wr_inc) seq.push_back(int'(bus.o_wr_src));
            if (acc && win == 3) begin
                beats++;
                dat[3] = $urandom;
                if (beats == 4) vld[3] = 0;
                else lst[3] = (beats == 3);
            end
            if (acc && win == 0) dat[0] = $urandom;
            if (c == 0) begin vld[0] = 1; lst[0] = 1; end
        end
        if (seq.size() < 6) begin
            miscompares++;
            $display("FAIL pkt_count got=%0d exp>=6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                int e;
                e = LOCK_EN ? exp_lk[i] : exp_rr[i];
                if (seq[i] != e) begin
                    miscompares++;
                    $display("FAIL pkt_order i=%0d got src=%0d exp=%0d", i, seq[i], e);
                end
                vectors++;
            end
        end
        vectors++;
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] obs, exp;
        int win; bit acc;
        apply_reset();
        vld[3] = 1; lst[3] = 0;
        for (int c = 0; c < 2; c++) begin
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rstmid_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (acc) dat[3] = $urandom;
        end
        rst = 1'b1;
        vld[0] = 1;
        @(posedge clk); #1;
        if ({bus.o_wr_inc, bus.o_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_clear got inc=%b busy=%b exp 0 0", bus.o_wr_inc, bus.o_busy);
        end
        vectors++;
        rst = 1'b0;
        model_reset();
        #1;
        if (bus.o_req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_first got ready=%b exp 0001", bus.o_req_ready);
        end
        vectors++;
        step(obs, exp, win, acc);
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL rstmid_after got=%h exp=%h", obs, exp);
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [BW-1:0] obs, exp;
        int win; bit acc;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!vld[k] && $urandom_range(0, 2) == 0) begin
                    vld[k] = 1; dat[k] = $urandom; lst[k] = ($urandom_range(0, 3) == 0);
                end
            end
            if (wr_ptr_q != rd_ptr && $urandom_range(0, 3) == 0) rd_ptr = rd_ptr + 1'b1;
            step(obs, exp, win, acc);
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rand_cycle c=%0d got=%h exp=%h", c, obs, exp);
            end
            vectors++;
            if (acc) vld[win] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin vld[k] = 0; lst[k] = 1; dat[k] = '0; end
        model_reset();
        test_reset();
        test_alternate();
        test_full();
        test_wrap();
        test_packet();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1);
    end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side arbiter for the dual-clock FIFO. It shares the single FIFO write port, driven by the write pointer/full controller, among P_NUM_REQ requesters in the write clock domain using round-robin arbitration. It throttles on pointer-derived free space, so the write controller never drops a write. It sits between the producer-side requesters and the write controller plus RAM write port.

## Interface
- P_NUM_REQ, 4: number of requesters (2..8).
- P_DATA_W, 32: data width per requester.
- P_PTR_MSB, 4: pointer MSB index, matching the write controller; the pointer is P_PTR_MSB+1 bits wide.
- P_SEL_W, 2: width of o_wr_src; must be at least clog2(P_NUM_REQ).

Ports:
- i_clk  in  1  write-domain clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  P_NUM_REQ  per-requester beat valid.
- i_req_data  in  P_NUM_REQ*P_DATA_W  per-requester data; requester k occupies slice [k*P_DATA_W +: P_DATA_W].
- i_req_last  in  P_NUM_REQ  last beat of packet; used only with packet lock.
- o_req_ready  out  P_NUM_REQ  combinational, one-hot or zero.
- i_wr_ptr  in  P_PTR_MSB+1  write pointer from the write controller.
- i_rd_ptr  in  P_PTR_MSB+1  read pointer, already synchronized into i_clk.
- o_wr_inc  out  1  registered write strobe, connects to the controller's i_inc.
- o_wr_data  out  P_DATA_W  registered RAM write data.
- o_wr_src  out  P_SEL_W  registered index of the requester that wrote.
- o_busy  out  1  high while locked or a write is in flight.

## Operation
- CAP = 2^(P_PTR_MSB+1) - 1 entries.
- used = (i_wr_ptr - i_rd_ptr) modulo 2^(P_PTR_MSB+1).
- space_ok = (used + o_wr_inc) < CAP. o_wr_inc counts the write already issued but not yet reflected in i_wr_ptr.
- Eligible set = {k : i_req_valid[k]}. In LOCK state the eligible set is restricted to the owner only.
- Winner selection: the first eligible index searching upward, modulo P_NUM_REQ, from r_last+1.
- Ready rule: o_req_ready[winner] = space_ok. All other ready bits are 0. If no requester is eligible, all ready bits are 0.
- Accept happens when valid & ready. On accept:
  - r_last <= winner.
  - o_wr_inc <= 1.
  - o_wr_data <= winner's data slice.
  - o_wr_src <= winner.
- With no accept, o_wr_inc <= 0. o_wr_data and o_wr_src hold their values.
- States:
  - IDLE -> LOCK(owner=winner): on accept with i_req_last[winner]=0 (packet lock only).
  - LOCK -> IDLE: on accept with i_req_last[owner]=1.
  - LOCK -> LOCK: while the owner is idle or stalled on space. Other requesters wait.
- Wrap-around: all pointer arithmetic is modulo 2^(P_PTR_MSB+1). A pointer wrap needs no special handling.
- Empty FIFO: used=0 and space_ok=1.
- Full FIFO: used+o_wr_inc=CAP. All ready bits are 0 until i_rd_ptr advances.
- o_busy = (state==LOCK) | o_wr_inc.

## Timing
- Reset values:
  - o_wr_inc=0, o_wr_data=0, o_wr_src=0, o_busy=0.
  - state=IDLE, r_last=P_NUM_REQ-1, so requester 0 wins first.
  - o_req_ready follows its rule from these values.
- Latency: an accept in cycle t gives o_wr_inc=1 in cycle t+1. i_wr_ptr increments one cycle after that.
- Throughput: one beat per cycle while space_ok holds.
- A requester must hold valid and data stable until its ready is seen.
- Simultaneous read advance and write: space_ok uses the current i_rd_ptr. It is conservative by up to the synchronizer delay.
- Reset mid-packet or mid-write:
  - Lock is dropped.
  - Any in-flight o_wr_inc is cleared on the next edge.
  - The write controller is reset together with this block.

## Configuration
- FIFO_WR_ARB_PKT_LOCK_EN defined: the IDLE/LOCK state machine is present, and a packet holds the port from its first beat to its last.
- Undefined: i_req_last is ignored, state is always IDLE, and arbitration is re-run on every beat (beat-level round-robin).

## Test plan
- Reset, then requesters 0 and 2 valid with empty pointers -> ready[0]=1 first; accepts alternate 0,2,0,2; o_wr_inc=1 each following cycle; o_wr_src follows the same order.
- P_PTR_MSB=4, hold i_rd_ptr=0 and drive 40 beats on requester 1, feeding back i_wr_ptr -> exactly 31 writes; ready stays 0 at used=31; one i_rd_ptr increment -> exactly one more write.
- i_wr_ptr=30, i_rd_ptr=31 (wrapped, used=31) -> no ready. Then i_rd_ptr=0 -> used=30, one accept allowed.
- FIFO_WR_ARB_PKT_LOCK_EN: requester 3 sends a 4-beat packet while requester 0 is valid -> four consecutive o_wr_src=3, then 0 wins. Without the macro -> 3,0,3,0 interleave.
- Assert i_rst in LOCK with o_wr_inc=1 -> next cycle o_wr_inc=0, o_busy=0, and requester 0 wins first after reset release.
